// File: rtl/wb_stage_if.sv
// Bus between the MEM/WB pipeline register, the ID-stage read ports and the
// write-back / register-file block. The consumer of WB results (pipeline,
// forwarding unit) is the master; the register file is the slave.
interface wb_stage_if #(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 19,
  parameter int ADDR_W  = 3,
  parameter int CNT_W   = 16
);
  logic [DATA_W-1:0]  MEM_WB_mem_out_data;
  logic [DATA_W-1:0]  MEM_WB_alu_out;
  logic [DATA_W-1:0]  MEM_WB_shift_out;
  logic [INSTR_W-1:0] MEM_WB_instruction;
  logic [1:0]         MEM_WB_reg_write_mux;
  logic [ADDR_W-1:0]  rd_addr_a;
  logic [ADDR_W-1:0]  rd_addr_b;
  logic [DATA_W-1:0]  rd_data_a;
  logic [DATA_W-1:0]  rd_data_b;
  logic               wb_en;
  logic [ADDR_W-1:0]  wb_addr;
  logic [DATA_W-1:0]  wb_data;
  logic [CNT_W-1:0]   retire_count;

  modport master (
    output MEM_WB_mem_out_data, MEM_WB_alu_out, MEM_WB_shift_out,
           MEM_WB_instruction, MEM_WB_reg_write_mux, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wb_en, wb_addr, wb_data, retire_count
  );

  modport slave (
    input  MEM_WB_mem_out_data, MEM_WB_alu_out, MEM_WB_shift_out,
           MEM_WB_instruction, MEM_WB_reg_write_mux, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wb_en, wb_addr, wb_data, retire_count
  );
endinterface

// File: rtl/wb_stage_regfile.sv
// Write-back stage plus register file. Selects the WB source, writes the
// destination register on the clock edge, serves two combinational read
// ports with same-cycle WB bypass, and counts committed register writes.
// R0 is hardwired to zero on both the array and the bypass path.
module wb_stage_regfile #(
  parameter int DATA_W   = 8,
  parameter int INSTR_W  = 19,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int RD_LSB   = 11,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  wb_stage_if.slave   bus
);

  logic [DATA_W-1:0] regs_reg [NUM_REGS];
  logic [CNT_W-1:0]  retire_count_reg;
  logic [DATA_W-1:0] wb_data_sel;
  logic [ADDR_W-1:0] wb_addr_sel;
  logic              wb_en_sel;

  assign wb_addr_sel = bus.MEM_WB_instruction[RD_LSB +: ADDR_W];
  assign wb_en_sel   = (bus.MEM_WB_reg_write_mux != 2'b00) && (wb_addr_sel != '0);

  // Write-back source select; code 00 means no write and forces zero data.
  always_comb begin
    wb_data_sel = '0;
    case (bus.MEM_WB_reg_write_mux)
      2'b01:   wb_data_sel = bus.MEM_WB_alu_out;
      2'b10:   wb_data_sel = bus.MEM_WB_mem_out_data;
      2'b11:   wb_data_sel = bus.MEM_WB_shift_out;
      default: wb_data_sel = '0;
    endcase
  end

  // One read port: R0 reads zero, a live WB to the same address is bypassed,
  // otherwise the stored value is returned.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] value;
    value = regs_reg[addr];
    if (addr == '0) begin
      value = '0;
    end else if (wb_en_sel && (addr == wb_addr_sel)) begin
      value = wb_data_sel;
    end
    return value;
  endfunction

  // Both read ports are independent and may bypass simultaneously.
  always_comb begin
    bus.rd_data_a = read_port(bus.rd_addr_a);
    bus.rd_data_b = read_port(bus.rd_addr_b);
  end

  // Register array; wb_en is never set for R0 so entry 0 stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wb_en_sel) begin
      regs_reg[wb_addr_sel] <= wb_data_sel;
    end
  end

  // Retire counter: one per committed write, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_count_reg <= '0;
    end else if (wb_en_sel) begin
      retire_count_reg <= retire_count_reg + CNT_W'(1);
    end
  end

  assign bus.wb_en        = wb_en_sel;
  assign bus.wb_addr      = wb_addr_sel;
  assign bus.wb_data      = wb_data_sel;
  assign bus.retire_count = retire_count_reg;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Self-checking bench for wb_stage_regfile: directed scenarios plus random
// write-back traffic compared against an array-based architectural model.
module tb_wb_stage_regfile;
  localparam int DATA_W   = 8;
  localparam int INSTR_W  = 19;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int RD_LSB   = 11;
  localparam int CNT_W    = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if #(.DATA_W(DATA_W), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();

  wb_stage_regfile #(
    .DATA_W(DATA_W), .INSTR_W(INSTR_W), .NUM_REGS(NUM_REGS),
    .ADDR_W(ADDR_W), .RD_LSB(RD_LSB), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Architectural model: register contents and number of committed writes.
  logic [DATA_W-1:0] model_regs [NUM_REGS];
  int unsigned       model_count;

  // Stimulus currently applied to the bus.
  logic [1:0]        cur_mux;
  logic [ADDR_W-1:0] cur_rd;
  logic [DATA_W-1:0] cur_alu, cur_mem, cur_shift;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_data();
    if (cur_mux == 2'd1) return cur_alu;
    if (cur_mux == 2'd2) return cur_mem;
    if (cur_mux == 2'd3) return cur_shift;
    return '0;
  endfunction

  function automatic logic exp_en();
    return (cur_mux != 2'd0) && (cur_rd != 0);
  endfunction

  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] addr);
    if (addr == 0) return '0;
    if (exp_en() && addr == cur_rd) return exp_data();
    return model_regs[addr];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
    model_count = 0;
  endtask

  task automatic set_inputs(input logic [1:0] mux, input logic [ADDR_W-1:0] rd,
                            input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                            input logic [DATA_W-1:0] shift,
                            input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    logic [INSTR_W-1:0] ins;
    ins = INSTR_W'($urandom);
    ins[RD_LSB +: ADDR_W] = rd;
    cur_mux = mux; cur_rd = rd; cur_alu = alu; cur_mem = mem; cur_shift = shift;
    bus.MEM_WB_reg_write_mux = mux;
    bus.MEM_WB_instruction   = ins;
    bus.MEM_WB_alu_out       = alu;
    bus.MEM_WB_mem_out_data  = mem;
    bus.MEM_WB_shift_out     = shift;
    bus.rd_addr_a            = a;
    bus.rd_addr_b            = b;
  endtask

  // Compare every combinational output and the counter against the model.
  task automatic check_comb(input string tag);
    check_eq({tag, "_wb_en"},   32'(bus.wb_en),        32'(exp_en()));
    check_eq({tag, "_wb_addr"}, 32'(bus.wb_addr),      32'(cur_rd));
    check_eq({tag, "_wb_data"}, 32'(bus.wb_data),      32'(exp_data()));
    check_eq({tag, "_rd_a"},    32'(bus.rd_data_a),    32'(exp_read(bus.rd_addr_a)));
    check_eq({tag, "_rd_b"},    32'(bus.rd_data_b),    32'(exp_read(bus.rd_addr_b)));
    check_eq({tag, "_retire"},  32'(bus.retire_count), model_count % (1 << CNT_W));
  endtask

  // Advance one clock edge and apply the architectural effect of that edge.
  task automatic clock_commit();
    logic              en;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    en = exp_en(); d = exp_data(); a = cur_rd;
    @(posedge clk);
    if (reset && en) begin
      model_regs[a] = d;
      model_count   = (model_count + 1) % (1 << CNT_W);
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [1:0]        m;
    logic [ADDR_W-1:0] rd, a, b;

    model_clear();
    set_inputs(2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0);

    // 1: reset, release, every address reads zero on both ports.
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      set_inputs(2'd0, 3'd5, 8'hFF, 8'hFF, 8'hFF, ADDR_W'(i), ADDR_W'(NUM_REGS - 1 - i));
      #1;
      check_eq($sformatf("t1_rd_a_r%0d", i), 32'(bus.rd_data_a), 32'h0);
      check_eq($sformatf("t1_rd_b_r%0d", i), 32'(bus.rd_data_b), 32'h0);
    end
    check_eq("t1_retire", 32'(bus.retire_count), 32'h0);
    $display("[%0t] reset release: all registers read 0, retire_count=%0d", $time, bus.retire_count);
    clock_commit();

    // 2: ALU write to R3, bypass then array read.
    set_inputs(2'd1, 3'd3, 8'h5A, 8'h00, 8'h00, 3'd3, 3'd0);
    #1;
    check_eq("t2_bypass_a", 32'(bus.rd_data_a), 32'h5A);
    check_comb("t2_w");
    clock_commit();
    set_inputs(2'd0, 3'd3, 8'h00, 8'h00, 8'h00, 3'd3, 3'd3);
    #1;
    check_eq("t2_array_a", 32'(bus.rd_data_a), 32'h5A);
    check_eq("t2_retire", 32'(bus.retire_count), 32'd1);
    check_comb("t2_r");
    $display("[%0t] R3<=0x5A bypass/array read 0x%0h retire=%0d", $time, bus.rd_data_a, bus.retire_count);
    clock_commit();

    // 3: memory write targeting R0 is suppressed.
    set_inputs(2'd2, 3'd0, 8'h00, 8'hC3, 8'h00, 3'd0, 3'd0);
    #1;
    check_eq("t3_wb_en", 32'(bus.wb_en), 32'd0);
    check_eq("t3_rd_a", 32'(bus.rd_data_a), 32'h0);
    check_comb("t3");
    clock_commit();
    check_eq("t3_retire", 32'(bus.retire_count), 32'd1);
    $display("[%0t] R0<=0xC3 ignored, retire=%0d", $time, bus.retire_count);

    // 4: shifter write to R7 with other sources at 0xFF, then no-write to R5.
    set_inputs(2'd3, 3'd7, 8'hFF, 8'hFF, 8'h81, 3'd7, 3'd5);
    #1;
    check_eq("t4_wb_data", 32'(bus.wb_data), 32'h81);
    check_comb("t4_w");
    clock_commit();
    set_inputs(2'd0, 3'd5, 8'hFF, 8'hFF, 8'hFF, 3'd7, 3'd5);
    #1;
    check_eq("t4_wb_data0", 32'(bus.wb_data), 32'h0);
    check_eq("t4_r7", 32'(bus.rd_data_a), 32'h81);
    check_eq("t4_r5", 32'(bus.rd_data_b), 32'h0);
    check_comb("t4_n");
    clock_commit();
    $display("[%0t] R7<=0x81 via shifter, R5 untouched", $time);

    // 5: back-to-back writes to R2, port B watching R2.
    set_inputs(2'd1, 3'd2, 8'h11, 8'h00, 8'h00, 3'd2, 3'd2);
    #1; check_eq("t5_b0", 32'(bus.rd_data_b), 32'h11); check_comb("t5_0");
    clock_commit();
    set_inputs(2'd2, 3'd2, 8'h00, 8'h22, 8'h00, 3'd0, 3'd2);
    #1; check_eq("t5_b1", 32'(bus.rd_data_b), 32'h22); check_comb("t5_1");
    clock_commit();
    set_inputs(2'd0, 3'd2, 8'h00, 8'h00, 8'h00, 3'd0, 3'd2);
    #1; check_eq("t5_b2", 32'(bus.rd_data_b), 32'h22); check_comb("t5_2");
    clock_commit();
    $display("[%0t] R2 back-to-back 0x11,0x22 observed on port B", $time);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      m  = 2'($urandom_range(0, 3));
      rd = ADDR_W'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? rd : ADDR_W'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? rd : ADDR_W'($urandom);
      set_inputs(m, rd, 8'($urandom), 8'($urandom), 8'($urandom), a, b);
      #1;
      check_comb($sformatf("rand%0d", n));
      $display("[%0t] rand%0d mux=%0d rd=%0d data=0x%0h a=%0d->0x%0h b=%0d->0x%0h retire=%0d",
               $time, n, m, rd, bus.wb_data, a, bus.rd_data_a, b, bus.rd_data_b, bus.retire_count);
      clock_commit();
    end

    // 6: counter wrap from a clean reset.
    do_reset();
    for (int n = 0; n < 65535; n++) begin
      set_inputs(2'd1, 3'd1, 8'(n), 8'h00, 8'h00, 3'd1, 3'd0);
      clock_commit();
    end
    set_inputs(2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 3'd1, 3'd0);
    #1;
    check_eq("t6_preload", 32'(bus.retire_count), 32'hFFFF);
    check_comb("t6_pre");
    $display("[%0t] retire_count preloaded to 0x%0h", $time, bus.retire_count);
    set_inputs(2'd3, 3'd6, 8'h00, 8'h00, 8'h3C, 3'd6, 3'd1);
    clock_commit();
    set_inputs(2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 3'd6, 3'd1);
    #1;
    check_eq("t6_wrap", 32'(bus.retire_count), 32'h0);
    check_comb("t6_post");
    $display("[%0t] retire_count wrapped to 0x%0h", $time, bus.retire_count);
    clock_commit();

    // 6: reset asserted mid-cycle during a write to R4.
    set_inputs(2'd1, 3'd4, 8'h77, 8'h00, 8'h00, 3'd4, 3'd6);
    #1;
    check_comb("t6_w");
    reset = 1'b0;
    model_clear();
    #1;
    check_eq("t6_rst_bypass", 32'(bus.rd_data_a), 32'h77);
    check_eq("t6_rst_r6", 32'(bus.rd_data_b), 32'h0);
    check_eq("t6_rst_retire", 32'(bus.retire_count), 32'h0);
    clock_commit();
    set_inputs(2'd0, 3'd4, 8'h00, 8'h00, 8'h00, 3'd4, 3'd4);
    #1;
    check_comb("t6_inrst");
    reset = 1'b1;
    #1;
    check_eq("t6_r4_a", 32'(bus.rd_data_a), 32'h0);
    check_eq("t6_r4_b", 32'(bus.rd_data_b), 32'h0);
    check_eq("t6_retire0", 32'(bus.retire_count), 32'h0);
    check_comb("t6_rel");
    clock_commit();
    $display("[%0t] R4<=0x77 discarded by reset, R4 reads 0x%0h", $time, bus.rd_data_a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
